// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared constants for the iterative RV32M multiply/divide sequencer
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam int ITERS   = 32;
    localparam int LATENCY = 36;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PREP_A = 3'd1;
    localparam logic [2:0] ST_PREP_B = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    function automatic logic signed_rs1(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_rs2(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_adder
// Brief    : Core ripple-carry adder, y = a + b + cin with carry out
// Revision : 1.0
// ============================================================================
module muldiv_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cout,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RV32M multiply/divide over one shared adder, fixed 36-cycle schedule
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    import muldiv_pkg::*;

    localparam int                c_CNT_W    = $clog2(ITERS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]   c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_opb;
    logic [XLEN-1:0]    r_spec_data;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_neg_res;
    logic               r_carry;
    logic               r_special;

    logic               w_accept;
    logic               w_is_div;
    logic               w_is_rem;
    logic               w_div_take;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic [XLEN-1:0]    w_shift;
    logic               w_add_cin;
    logic [XLEN-1:0]    w_add_a;
    logic [XLEN-1:0]    w_add_b;
    logic               w_add_cout;
    logic [XLEN-1:0]    w_add_y;

    assign w_accept   = req_valid & req_ready & ~flush;
    assign w_is_div   = r_funct3[2];
    assign w_is_rem   = r_funct3[2] & r_funct3[1];
    assign w_shift    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    // R[31] set means the 33-bit shifted remainder already exceeds any divisor
    assign w_div_take = r_hi[XLEN-1] | w_add_cout;

    assign w_neg_a  = signed_rs1(req_funct3) & req_a[XLEN-1];
    assign w_neg_b  = signed_rs2(req_funct3) & req_b[XLEN-1];
    assign w_b_zero = (req_b == '0);
    assign w_ovf    = signed_rs2(req_funct3) & req_funct3[2] &
                      (req_a == c_INT_MIN) & (req_b == '1);

    muldiv_seq_adder #(
        .WIDTH (XLEN)
    ) u_adder (
        .cin  (w_add_cin),
        .a    (w_add_a),
        .b    (w_add_b),
        .cout (w_add_cout),
        .y    (w_add_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_PREP_A;
            ST_PREP_A: w_state_nxt = ST_PREP_B;
            ST_PREP_B: w_state_nxt = ST_ITER;
            ST_ITER:   if (r_cnt == c_CNT_LAST) w_state_nxt = ST_FIX_LO;
            ST_FIX_LO: w_state_nxt = ST_FIX_HI;
            ST_FIX_HI: w_state_nxt = ST_DONE;
            ST_DONE:   if (resp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        resp_valid = (r_state == ST_DONE);
        resp_data  = '0;
        if (r_state == ST_DONE) begin
            if (r_special) begin
                resp_data = r_spec_data;
            end else if (r_funct3 == F3_MUL) begin
                resp_data = r_lo;
            end else if (w_is_div) begin
                resp_data = w_is_rem ? r_hi : r_lo;
            end else begin
                resp_data = r_hi;
            end
        end
    end

    // Adder operand mux: every negation is ~x + 1 (or ~x + carry for the high word)
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_PREP_A: begin
                w_add_a   = ~r_lo;
                w_add_cin = 1'b1;
            end
            ST_PREP_B: begin
                w_add_a   = ~r_opb;
                w_add_cin = 1'b1;
            end
            ST_ITER: begin
                if (w_is_div) begin
                    w_add_a   = w_shift;
                    w_add_b   = ~r_opb;
                    w_add_cin = 1'b1;
                end else begin
                    w_add_a = r_hi;
                    w_add_b = r_lo[0] ? r_opb : '0;
                end
            end
            ST_FIX_LO: begin
                w_add_a   = w_is_rem ? ~r_hi : ~r_lo;
                w_add_cin = 1'b1;
            end
            ST_FIX_HI: begin
                w_add_a   = ~r_hi;
                w_add_cin = r_carry;
            end
            default: begin
                w_add_a   = '0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_funct3    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opb       <= '0;
            r_spec_data <= '0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_neg_res   <= 1'b0;
            r_carry     <= 1'b0;
            r_special   <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_funct3  <= req_funct3;
            r_hi      <= '0;
            r_lo      <= req_a;
            r_opb     <= req_b;
            r_carry   <= 1'b0;
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_neg_res <= (req_funct3 == F3_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);
            r_special <= req_funct3[2] & (w_b_zero | w_ovf);
            if (w_b_zero) begin
                r_spec_data <= req_funct3[1] ? req_a : '1;
            end else begin
                r_spec_data <= req_funct3[1] ? '0 : c_INT_MIN;
            end
        end else begin
            case (r_state)
                ST_PREP_A: if (r_neg_a) r_lo <= w_add_y;
                ST_PREP_B: if (r_neg_b) r_opb <= w_add_y;
                ST_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_is_div) begin
                        {r_hi, r_lo} <= {w_add_cout, w_add_y, r_lo[XLEN-1:1]};
                    end else if (w_div_take) begin
                        r_hi <= w_add_y;
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= w_shift;
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end
                ST_FIX_LO: begin
                    if (r_neg_res) begin
                        if (!w_is_div) begin
                            r_lo    <= w_add_y;
                            r_carry <= w_add_cout;
                        end else if (w_is_rem) begin
                            r_hi <= w_add_y;
                        end else begin
                            r_lo <= w_add_y;
                        end
                    end
                end
                ST_FIX_HI: if (r_neg_res && !w_is_div) r_hi <= w_add_y;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq against an arithmetic reference model
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_seq #(
        .XLEN  (32),
        .ITERS (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        check("issue_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        tick();
        req_valid  = 1'b0;
    endtask

    // Cycles counted from the accepting edge to the first cycle resp_valid is seen
    task automatic wait_resp(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!resp_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   lat;
        logic bok;
        issue(f3, a, b);
        wait_resp(lat, bok);
        check({tag, "_lat"},  32'(lat), 32'd36);
        check({tag, "_busy"}, {31'b0, bok & busy}, 32'd1);
        check({tag, "_data"}, resp_data, exp);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic        seen;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        rst_n      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_resp_data",  resp_data,           32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run_op("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu",     3'd5, 32'd100,        32'd7,         32'd14);
        run_op("remu",     3'd7, 32'd100,        32'd7,         32'd2);
        run_op("divu_z",   3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
        run_op("remu_z",   3'd7, 32'h1234,       32'd0,         32'h1234);
        run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("rnd", f3, a, b, ref_model(f3, a, b));
        end

        // Backpressure with a competing request that must not be accepted
        issue(3'd5, 32'd1000, 32'd7);
        wait_resp(lat, bok);
        check("bp_lat", 32'(lat), 32'd36);
        req_valid  = 1'b1;
        req_funct3 = 3'd0;
        req_a      = 32'd3;
        req_b      = 32'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_data",  resp_data,           32'd142);
            check("bp_ready", {31'b0, req_ready},  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_release_valid", {31'b0, resp_valid}, 32'd0);
        run_op("bp_next", 3'd0, 32'd6, 32'd7, 32'd42);

        // Flush in the middle of the iterations
        issue(3'd4, 32'hDEAD_BEEF, 32'd13);
        repeat (12) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy",  {31'b0, busy},       32'd0);
        check("flush_ready", {31'b0, req_ready},  32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen = 1'b1;
            tick();
        end
        check("flush_no_resp", {31'b0, seen}, 32'd0);

        // Flush in IDLE blocks acceptance
        req_valid  = 1'b1;
        req_funct3 = 3'd0;
        req_a      = 32'd2;
        req_b      = 32'd2;
        flush      = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle_busy", {31'b0, busy}, 32'd0);

        // Flush in DONE drops the result
        issue(3'd0, 32'd9, 32'd9);
        wait_resp(lat, bok);
        check("flush_done_lat", 32'(lat), 32'd36);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_valid", {31'b0, resp_valid}, 32'd0);
        check("flush_done_ready", {31'b0, req_ready},  32'd1);

        // Asynchronous reset while in FIX_LO
        issue(3'd1, 32'hFFFF_1234, 32'h0000_5678);
        repeat (34) tick();
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, req_ready},  32'd1);
        check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_busy",  {31'b0, busy},       32'd0);
        check("mid_rst_data",  resp_data,           32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op("post_rst_mul", 3'd0, 32'd3, 32'd5, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
